filter_unit: RTL

Stage directly downstream of the input buffer in the trace pipeline. Takes one N-lane vector per cycle and tests every lane against M runtime-configurable inclusive signed ranges [min, max]. Emits the vector plus an M×N match mask two cycles later. Thresholds are loaded byte-serially over the shared 8-bit configuration bus while tracing is off.

---
 rtl/trace_pkg.sv | 16 +
 rtl/filter_cfg_loader.sv | 92 +++++++++
 rtl/filter_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace pipeline: configuration loader states and
// the layout of the byte-serial configuration header.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_SEEN = 2'd1,
        DATA     = 2'd2,
        COMMIT   = 2'd3
    } cfg_state_e;

    localparam int         CFG_FIELD_BIT = 7;
    localparam int         CFG_IDX_BITS  = 7;
    localparam logic [7:0] CFG_ID_IDLE   = 8'd0;

endpackage

// File: rtl/filter_cfg_loader.sv
// Byte-serial threshold loader: header byte, then DATA_WIDTH/8 data bytes MSB
// first, then a one-cycle write strobe. Any gap or tracing mid-sequence aborts.
module filter_cfg_loader
    import trace_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CFG_ID     = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tracing,
    input  logic [7:0]              config_id,
    input  logic [7:0]              config_data,
    output logic                    wr_en,
    output logic                    wr_field,
    output logic [CFG_IDX_BITS-1:0] wr_idx,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output cfg_state_e              state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(BYTES) + 1;

    cfg_state_e              state_next;
    logic                    qualify;
    logic                    shift_en;
    logic                    last_byte;
    logic [CNT_W-1:0]        cnt_q;
    logic                    field_q;
    logic [CFG_IDX_BITS-1:0] idx_q;
    logic [DATA_WIDTH-1:0]   staging_q;

    assign qualify = (config_id == 8'(CFG_ID)) && !tracing;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        if (state == HDR_SEEN) begin
            last_byte = (BYTES == 1);
        end else begin
            last_byte = (cnt_q == CNT_W'(BYTES - 1));
        end
        case (state)
            IDLE: begin
                if (qualify) state_next = HDR_SEEN;
            end
            HDR_SEEN, DATA: begin
                if (!qualify) begin
                    state_next = IDLE;
                end else begin
                    shift_en   = 1'b1;
                    state_next = last_byte ? COMMIT : DATA;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Header latch, byte counter and staging shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            field_q   <= 1'b0;
            idx_q     <= '0;
            staging_q <= '0;
        end else begin
            if (state == IDLE && qualify) begin
                field_q <= config_data[CFG_FIELD_BIT];
                idx_q   <= config_data[CFG_IDX_BITS-1:0];
            end
            if (shift_en) begin
                staging_q <= DATA_WIDTH'({staging_q, config_data});
                cnt_q     <= (state == HDR_SEEN) ? CNT_W'(1) : cnt_q + CNT_W'(1);
            end
        end
    end

    assign wr_en    = (state == COMMIT);
    assign wr_field = field_q;
    assign wr_idx   = idx_q;
    assign wr_data  = staging_q;

endmodule

// File: rtl/filter_unit.sv
// Two-stage range filter: every lane is tested against M signed inclusive
// ranges; the vector and its M x N match mask emerge two cycles later.
module filter_unit
    import trace_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int M          = 2,
    parameter int CFG_ID     = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           valid_in,
    input  logic                           eof_in,
    input  logic                           chainId_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
    input  logic                           tracing,
    input  logic [7:0]                     config_id,
    input  logic [7:0]                     config_data,
    output logic                           valid_out,
    output logic                           eof_out,
    output logic                           chainId_out,
    output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
    output logic [M-1:0][N-1:0]            filter_out,
    output logic                           cfg_busy
);

    logic                          wr_en;
    logic                          wr_field;
    logic [CFG_IDX_BITS-1:0]       wr_idx;
    logic [DATA_WIDTH-1:0]         wr_data;
    cfg_state_e                    cfg_state;

    logic [M-1:0][DATA_WIDTH-1:0]  min_q;
    logic [M-1:0][DATA_WIDTH-1:0]  max_q;

    logic                          s1_valid;
    logic                          s1_eof;
    logic                          s1_chain;
    logic [N-1:0][DATA_WIDTH-1:0]  s1_vector;
    logic [M-1:0][N-1:0]           match;

    filter_cfg_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .CFG_ID     (CFG_ID)
    ) u_loader (
        .clk         (clk),
        .reset_n     (reset_n),
        .tracing     (tracing),
        .config_id   (config_id),
        .config_data (config_data),
        .wr_en       (wr_en),
        .wr_field    (wr_field),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .state       (cfg_state)
    );

    assign cfg_busy = (cfg_state != IDLE);

    // min=1/max=0 is an empty range; out-of-range indices match no slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < M; m++) begin
                min_q[m] <= DATA_WIDTH'(1);
                max_q[m] <= '0;
            end
        end else if (wr_en) begin
            for (int m = 0; m < M; m++) begin
                if (wr_idx == CFG_IDX_BITS'(m)) begin
                    if (wr_field) max_q[m] <= wr_data;
                    else          min_q[m] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        match = '0;
        for (int m = 0; m < M; m++) begin
            for (int i = 0; i < N; i++) begin
                match[m][i] = ($signed(s1_vector[i]) >= $signed(min_q[m])) &&
                              ($signed(s1_vector[i]) <= $signed(max_q[m]));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_eof      <= 1'b0;
            s1_chain    <= 1'b0;
            s1_vector   <= '0;
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            chainId_out <= 1'b0;
            vector_out  <= '0;
            filter_out  <= '0;
        end else begin
            s1_valid    <= valid_in;
            s1_eof      <= eof_in;
            s1_chain    <= chainId_in;
            s1_vector   <= vector_in;
            valid_out   <= s1_valid;
            eof_out     <= s1_eof;
            chainId_out <= s1_chain;
            vector_out  <= s1_vector;
            filter_out  <= match;
        end
    end

endmodule
